// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked arbiter that shares one UART TX
// byte interface (data/valid/ready) among NUM_REQ requesters. The winner keeps
// the transmitter until one of its bytes flagged last has been handed to TX.
// A one-byte output buffer sits between the owner and the TX block.
//
// Optional build macro: TX_ARB_LOCK_TIMEOUT_EN
//   defined   - a stalled owner (no byte offered, buffer empty) loses the lock
//               after LOCK_TIMEOUT idle GRANT cycles and lock_timeout pulses.
//   undefined - no stall counter; lock_timeout is constant 0 and a stalled
//               owner keeps the lock until reset.

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 500000,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic                 lock_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_r;
    logic [ID_W-1:0]     last_grant_r;
    logic [ID_W-1:0]     grant_id_r;
    logic                busy_r;
    logic                tx_valid_r;
    logic [7:0]          tx_data_r;

    logic [NUM_REQ-1:0]  req_ready_s;
    logic                any_req_s;
    logic [ID_W-1:0]     winner_s;
    logic                own_valid_s;
    logic                own_last_s;
    logic [7:0]          own_data_s;
    logic                accept_s;
    logic                handoff_s;

    // Round-robin pick: first valid requester after 'last', wrapping. The scan
    // runs from the farthest offset down so the nearest valid one wins.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                input logic [ID_W-1:0]    last);
        logic [ID_W-1:0] pick;
        int              idx;
        pick = last;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = int'(last) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (valid[idx]) begin
                pick = ID_W'(idx);
            end
        end
        return pick;
    endfunction

    assign any_req_s   = |req_valid;
    assign winner_s    = rr_pick(req_valid, last_grant_r);
    assign own_valid_s = req_valid[grant_id_r];
    assign own_last_s  = req_last[grant_id_r];
    assign own_data_s  = req_data[{grant_id_r, 3'b000} +: 8];
    assign accept_s    = (state_r == ST_GRANT) && own_valid_s && !tx_valid_r;
    assign handoff_s   = tx_valid_r && tx_ready;

    // Owner may push a byte only while the output buffer is empty.
    always_comb begin
        req_ready_s = '0;
        if (state_r == ST_GRANT) begin
            req_ready_s[grant_id_r] = ~tx_valid_r;
        end else begin
            req_ready_s = '0;
        end
    end

`ifdef TX_ARB_LOCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    logic [CNT_W-1:0] stall_cnt_r;
    logic             lock_timeout_r;
    logic             stall_s;

    assign stall_s = (state_r == ST_GRANT) && !tx_valid_r && !own_valid_s;

    // Arbitration FSM, output buffer and stalled-lock release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            last_grant_r   <= ID_W'(NUM_REQ - 1);
            grant_id_r     <= '0;
            busy_r         <= 1'b0;
            tx_valid_r     <= 1'b0;
            tx_data_r      <= 8'h00;
            stall_cnt_r    <= '0;
            lock_timeout_r <= 1'b0;
        end else begin
            lock_timeout_r <= 1'b0;
            if (handoff_s) begin
                tx_valid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        grant_id_r  <= winner_s;
                        busy_r      <= 1'b1;
                        stall_cnt_r <= '0;
                        state_r     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (accept_s) begin
                        tx_data_r   <= own_data_s;
                        tx_valid_r  <= 1'b1;
                        stall_cnt_r <= '0;
                        if (own_last_s) begin
                            state_r <= ST_DRAIN;
                        end
                    end else if (stall_s) begin
                        if (stall_cnt_r == CNT_W'(LOCK_TIMEOUT - 1)) begin
                            lock_timeout_r <= 1'b1;
                            last_grant_r   <= grant_id_r;
                            busy_r         <= 1'b0;
                            stall_cnt_r    <= '0;
                            state_r        <= ST_IDLE;
                        end else begin
                            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (handoff_s) begin
                        last_grant_r <= grant_id_r;
                        busy_r       <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    busy_r     <= 1'b0;
                    tx_valid_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign lock_timeout = lock_timeout_r;
`else
    // Arbitration FSM and output buffer; a stalled owner holds the lock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            last_grant_r <= ID_W'(NUM_REQ - 1);
            grant_id_r   <= '0;
            busy_r       <= 1'b0;
            tx_valid_r   <= 1'b0;
            tx_data_r    <= 8'h00;
        end else begin
            if (handoff_s) begin
                tx_valid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        grant_id_r <= winner_s;
                        busy_r     <= 1'b1;
                        state_r    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (accept_s) begin
                        tx_data_r  <= own_data_s;
                        tx_valid_r <= 1'b1;
                        if (own_last_s) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (handoff_s) begin
                        last_grant_r <= grant_id_r;
                        busy_r       <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    busy_r     <= 1'b0;
                    tx_valid_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign lock_timeout = 1'b0;
`endif

    assign req_ready = req_ready_s;
    assign tx_data   = tx_data_r;
    assign tx_valid  = tx_valid_r;
    assign grant_id  = grant_id_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester tasks push the byte and
// requester index they expect on the TX side when the arbiter accepts them;
// an independent monitor pops and compares on every TX hand-off.

module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef struct packed {
        logic [7:0]      data;
        logic [ID_W-1:0] id;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [ID_W-1:0]      grant_id;
    logic                 busy;
    logic                 lock_timeout;

    logic [7:0] d_arr [NUM_REQ];
    logic       v_arr [NUM_REQ];
    logic       l_arr [NUM_REQ];
    int         acc_cnt [NUM_REQ];

    exp_t exp_q[$];
    int   tests;
    int   fails;
    int   hs_cnt;
    logic sink_en;
    logic done3;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .LOCK_TIMEOUT (16),
        .ID_W         (ID_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_data     (req_data),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .grant_id     (grant_id),
        .busy         (busy),
        .lock_timeout (lock_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack per-requester stimulus into the DUT's flat buses.
    always_comb begin
        req_data  = '0;
        req_valid = '0;
        req_last  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[8*i +: 8] = d_arr[i];
            req_valid[i]       = v_arr[i];
            req_last[i]        = l_arr[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // TX sink: take each buffered byte one cycle after it appears.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = sink_en && tx_valid && !tx_ready;
        end
    end

    // Monitor: every hand-off must match the oldest expected byte and owner.
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            hs_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL tx_unexpected: got data %0h id %0d expected none", tx_data, grant_id);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (tx_data !== e.data || grant_id !== e.id) begin
                    fails++;
                    $display("FAIL tx_byte: got data %0h id %0d expected data %0h id %0d",
                             tx_data, grant_id, e.data, e.id);
                end
            end
        end
    end

    // Requester: offer n bytes (byte k at bytes[8k+:8]); last flag on final byte if 'last'.
    task automatic send_pkt(input int id, input int n, input logic [31:0] bytes, input logic last);
        int   cyc;
        exp_t e;
        for (int k = 0; k < n; k++) begin
            d_arr[id] = bytes[8*k +: 8];
            l_arr[id] = (k == n - 1) && last;
            v_arr[id] = 1'b1;
            cyc = 0;
            @(negedge clk);
            while (!req_ready[id] && cyc < 2000) begin
                @(negedge clk);
                cyc++;
            end
            if (!req_ready[id]) begin
                check("accept_timeout", 32'(id), 32'hFFFF);
                break;
            end
            e.data = bytes[8*k +: 8];
            e.id   = ID_W'(id);
            exp_q.push_back(e);
            acc_cnt[id]++;
            @(posedge clk);
            #1;
        end
        v_arr[id] = 1'b0;
        l_arr[id] = 1'b0;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        @(negedge clk);
        while ((busy || tx_valid) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("wait_idle", {31'd0, busy || tx_valid}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v_arr[i] = 1'b0;
            l_arr[i] = 1'b0;
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Two requesters valid together: expect 'first' then 'second' to own the TX.
    task automatic arb_pair(input int first, input int second);
        fork
            send_pkt(first, 2, 32'h0000_A1A0 + 32'(first), 1'b1);
            send_pkt(second, 1, 32'h0000_00B0 + 32'(second), 1'b1);
            begin
                int c;
                @(posedge clk);
                #1;
                check("pair_first_grant", {30'd0, grant_id}, 32'(first));
                check("pair_first_busy", {31'd0, busy}, 32'd1);
                c = 0;
                @(negedge clk);
                while (busy && c < 500) begin
                    @(negedge clk);
                    c++;
                end
                @(posedge clk);
                #1;
                check("pair_second_grant", {30'd0, grant_id}, 32'(second));
                check("pair_second_busy", {31'd0, busy}, 32'd1);
            end
        join
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests   = 0;
        fails   = 0;
        hs_cnt  = 0;
        sink_en = 1'b1;
        done3   = 1'b0;
        rst_n   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            d_arr[i]   = 8'h00;
            v_arr[i]   = 1'b0;
            l_arr[i]   = 1'b0;
            acc_cnt[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_grant_id", {30'd0, grant_id}, 32'd0);
        check("rst_req_ready", {28'd0, req_ready}, 32'd0);
        check("rst_lock_timeout", {31'd0, lock_timeout}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single requester 1, two bytes
        fork
            send_pkt(1, 2, 32'h0000_4241, 1'b1);
            begin
                @(posedge clk);
                #1;
                check("t1_grant", {30'd0, grant_id}, 32'd1);
                check("t1_busy", {31'd0, busy}, 32'd1);
            end
        join
        wait_idle();
        check("t1_busy_fall", {31'd0, busy}, 32'd0);

        // Requesters 0 and 2 after reset, then again with pointer at 2
        do_reset();
        arb_pair(0, 2);
        arb_pair(0, 2);

        // Requester 3 mid-packet while requester 1 waits
        done3 = 1'b0;
        fork
            begin
                send_pkt(3, 4, 32'h3433_3231, 1'b1);
                done3 = 1'b1;
            end
            begin
                int c;
                c = 0;
                while (acc_cnt[3] < 2 && c < 500) begin
                    @(posedge clk);
                    #1;
                    c++;
                end
                send_pkt(1, 1, 32'h0000_00D1, 1'b1);
            end
            begin
                int viol;
                viol = 0;
                while (!done3) begin
                    @(negedge clk);
                    if (req_ready[1]) viol++;
                end
                check("t3_ready1_blocked", 32'(viol), 32'd0);
            end
        join
        wait_idle();

        // TX stalled for 100 cycles with 8'h5A buffered
        sink_en = 1'b0;
        send_pkt(0, 1, 32'h0000_005A, 1'b1);
        begin
            int bad;
            int h0;
            bad = 0;
            for (int i = 0; i < 100; i++) begin
                @(posedge clk);
                #1;
                if (!tx_valid || tx_data !== 8'h5A || req_ready !== 4'b0000) bad++;
            end
            check("t4_hold_stable", 32'(bad), 32'd0);
            h0 = hs_cnt;
            sink_en = 1'b1;
            wait_idle();
            check("t4_one_handoff", 32'(hs_cnt - h0), 32'd1);
        end

        // Reset while in DRAIN
        sink_en = 1'b0;
        send_pkt(0, 1, 32'h0000_0077, 1'b1);
        check("t5_buffered", {31'd0, tx_valid}, 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("t5_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        rst_n   = 1'b1;
        sink_en = 1'b1;
        fork
            send_pkt(0, 1, 32'h0000_0033, 1'b1);
            begin
                @(posedge clk);
                #1;
                check("t5_regrant_busy", {31'd0, busy}, 32'd1);
                check("t5_regrant_id", {30'd0, grant_id}, 32'd0);
            end
        join
        wait_idle();

        // Owner 0 stalls after a non-last byte while requester 2 waits
        send_pkt(0, 1, 32'h0000_0011, 1'b0);
        d_arr[2] = 8'hC3;
        l_arr[2] = 1'b1;
        v_arr[2] = 1'b1;
        begin
            int c;
            c = 0;
            while (tx_valid && c < 10) begin
                @(posedge clk);
                #1;
                c++;
            end
`ifdef TX_ARB_LOCK_TIMEOUT_EN
            c = 0;
            while (!lock_timeout && c < 100) begin
                @(posedge clk);
                #1;
                c++;
            end
            check("t6_timeout_cycle", 32'(c), 32'd16);
            @(posedge clk);
            #1;
            v_arr[2] = 1'b0;
            check("t6_pulse_width", {31'd0, lock_timeout}, 32'd0);
            check("t6_busy", {31'd0, busy}, 32'd1);
            check("t6_grant2", {30'd0, grant_id}, 32'd2);
`else
            c = 0;
            for (int i = 0; i < 1000; i++) begin
                @(posedge clk);
                #1;
                if (lock_timeout) c++;
            end
            check("t6_no_pulse", 32'(c), 32'd0);
            check("t6_still_busy", {31'd0, busy}, 32'd1);
            check("t6_still_owner", {30'd0, grant_id}, 32'd0);
            check("t6_no_ready", {28'd0, req_ready}, 32'b0001);
`endif
        end
        do_reset();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART TX byte interface (data/valid/ready, transfer on valid && ready) among NUM_REQ requesters. Grants are packet-locked: the winning requester keeps the transmitter until it sends a byte flagged last. It sits between client logic (echo path, status reporter, debug dump) and the single TX instance in the UART top.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LOCK_TIMEOUT, 500000, idle cycles before a stalled lock is dropped (used only under the optional feature)
ID_W, $clog2(NUM_REQ), width of grant_id

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset, sampled on posedge clk
req_data  in  NUM_REQ*8  byte from requester i at bits [8i+7:8i]
req_valid  in  NUM_REQ  requester i presents a byte
req_last  in  NUM_REQ  byte from requester i is the final byte of its packet
req_ready  out  NUM_REQ  byte from requester i accepted this cycle if req_valid[i]
tx_data  out  8  byte to the TX block
tx_valid  out  1  tx_data valid
tx_ready  in  1  TX block idle and able to take a byte
grant_id  out  ID_W  index of the current owner (valid while busy)
busy  out  1  a requester holds the lock
lock_timeout  out  1  one-cycle pulse when a stalled lock is dropped (constant 0 without the feature)

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; tx_valid=0; tx_data=8'h00; req_ready=0; grant_id=0; busy=0; lock_timeout=0; RR pointer last_grant=NUM_REQ-1, so requester 0 wins first.
- States: IDLE, GRANT, DRAIN.
- IDLE: busy=0, req_ready=0. If any req_valid: winner = first set bit scanning last_grant+1, last_grant+2, ... (wrap mod NUM_REQ). Register grant_id=winner, busy=1, go to GRANT next cycle. Request-to-grant latency: 1 cycle.
- GRANT: req_ready[grant_id] = ~tx_valid, combinational; all other req_ready bits 0. On req_valid[g] && req_ready[g]: tx_data<=byte, tx_valid<=1, last_r<=req_last[g]; if req_last[g], go to DRAIN. Accept-to-tx_valid latency: 1 cycle.
- Output buffer: tx_valid stays high, tx_data stable until tx_valid && tx_ready, then tx_valid<=0. The output buffer holds one byte. Because req_ready requires an empty buffer, acceptance and hand-off never happen in the same cycle.
- DRAIN: req_ready=0. On tx_valid && tx_ready: tx_valid<=0, last_grant<=grant_id, busy<=0, go to IDLE. The new arbitration starts the following cycle. The just-finished requester gets lowest priority.
- Single-byte packet: valid with last=1 goes directly GRANT->DRAIN.
- The owner may drop req_valid mid-packet. The lock holds and other requesters wait. See the optional feature for how a stalled lock is released.
- Non-owner req_valid is ignored and never gets req_ready. Requesters must hold data stable until accepted.
- Only one requester valid: it is granted regardless of pointer position.
- Reset mid-packet: all state clears the same cycle and tx_valid drops. A byte already latched by TX completes on the line; the arbiter does not track it.
- tx_ready held low: the buffer holds indefinitely with no loss and no further accepts.

Optional Feature:
Macro TX_ARB_LOCK_TIMEOUT_EN.
- Defined: a counter clears on every accept and on entry to GRANT. It increments each GRANT cycle where tx_valid=0 and req_valid[grant_id]=0. When it reaches LOCK_TIMEOUT-1: pulse lock_timeout for 1 cycle, last_grant<=grant_id, busy<=0, go to IDLE. The timeout is not active in DRAIN.
- Not defined: no counter; lock_timeout tied 0; a stalled owner keeps the lock until reset.

Test Plan:
- Single requester 1 sends 8'h41,8'h42(last), tx_ready pulses 1 cycle after each tx_valid -> tx_data sequence 41,42; grant_id=1; busy falls the cycle after the second hand-off.
- Requesters 0 and 2 both valid in IDLE after reset -> 0 granted first; after its last byte, 2 granted the next cycle; then 0 and 2 valid again -> 0 granted (pointer at 2).
- Requester 3 mid-packet (2 of 4 bytes sent) while requester 1 asserts valid -> req_ready[1] stays 0 until requester 3's last byte drains; no bytes interleave on tx_data.
- tx_ready held 0 for 100 cycles with byte 8'h5A buffered -> tx_valid=1 and tx_data=8'h5A stable throughout; req_ready=0; one hand-off when tx_ready rises.
- rst_n low for 1 cycle during DRAIN -> next cycle tx_valid=0, busy=0, state IDLE; pending requester 0 granted 1 cycle after rst_n rises.
- With TX_ARB_LOCK_TIMEOUT_EN and LOCK_TIMEOUT=16: owner drops valid after a non-last byte, requester 2 pending -> lock_timeout pulses on the 16th stalled cycle; requester 2 granted the following cycle. Without the macro -> no release after 1000 cycles.
